key_expander: RTL and testbench

- Iterative, clocked AES key-schedule generator. It replaces the fixed-key lookup with true expansion of an arbitrary cipher key.
- Supports AES-128 and AES-256 by parameter. It computes one 32-bit schedule word per cycle and stores all round keys in an internal register file.
- The round datapath reads keys through a round_number / round_key port, which has one cycle of read latency.
- Instantiates 4 copies of the existing sbox (input_byte/output_byte).

---
 rtl/key_expander.sv | 158 +++++++++++++++
 tb/tb_key_expander.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_expander.sv
// AES key-schedule generator: expands a 128/256-bit cipher key one 32-bit word per cycle
// into NR+1 stored round keys, read back through a registered round_number port.

module sbox (
    input  logic [7:0] input_byte,
    output logic [7:0] output_byte
);
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // GF(2^8) inverse as a^254 = product of a^(2^k) for k=1..7; maps 0 to 0.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv         = ginv(input_byte);
        output_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module key_expander #(
    parameter int KEY_BITS = 128,
    parameter int NK       = KEY_BITS / 32,
    parameter int NR       = NK + 6,
    parameter int NW       = 4 * (NR + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] cipher_key,
    output logic                busy,
    output logic                keys_valid,
    output logic                done,
    input  logic [3:0]          round_number,
    output logic [127:0]        round_key
);
    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $fatal(1, "key_expander: KEY_BITS must be 128 or 256");
    end

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [5:0]    idx;
    logic [7:0]    rcon;
    logic [31:0]   win [NK];
    logic [127:0]  rk [NR+1];

    logic          accept;
    logic          is_rcon;
    logic          is_sub4;
    logic          last;
    logic [31:0]   prev;
    logic [31:0]   sub_in;
    logic [31:0]   sub_out;
    logic [31:0]   t;
    logic [31:0]   w_new;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Window: win[0] is w[i-NK], win[NK-1] is w[i-1].
    always_comb begin
        prev    = win[NK-1];
        is_rcon = (idx & 6'(NK - 1)) == 6'd0;
        is_sub4 = (NK == 8) && (idx[2:0] == 3'd4);
        last    = idx == 6'(NW - 1);
        sub_in  = is_rcon ? {prev[23:0], prev[31:24]} : prev;
        if (is_rcon)
            t = sub_out ^ {rcon, 24'h0};
        else if (is_sub4)
            t = sub_out;
        else
            t = prev;
        w_new   = win[0] ^ t;
    end

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        sbox u_sbox (
            .input_byte  (sub_in[8*b +: 8]),
            .output_byte (sub_out[8*b +: 8])
        );
    end

    assign accept = (state == IDLE) && start;
    assign busy   = state == EXPAND;
    assign done   = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = EXPAND;
            EXPAND:  if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            rcon       <= '0;
            keys_valid <= 1'b0;
            round_key  <= '0;
            for (int k = 0; k < NK; k++) win[k] <= '0;
            for (int k = 0; k <= NR; k++) rk[k] <= '0;
        end else begin
            round_key <= (round_number <= 4'(NR)) ? rk[round_number] : '0;
            if (accept) begin
                for (int k = 0; k < NK; k++) win[k] <= cipher_key[KEY_BITS-1-32*k -: 32];
                for (int k = 0; k < NK/4; k++) rk[k] <= cipher_key[KEY_BITS-1-128*k -: 128];
                idx        <= 6'(NK);
                rcon       <= 8'h01;
                keys_valid <= 1'b0;
            end else if (state == EXPAND) begin
                for (int k = 0; k < NK-1; k++) win[k] <= win[k+1];
                win[NK-1] <= w_new;
                // slot 0 of a round key sits at [127:96]
                rk[idx[5:2]][{~idx[1:0], 5'b0} +: 32] <= w_new;
                idx <= idx + 6'd1;
                if (is_rcon) rcon <= xtime(rcon);
                if (last) keys_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_key_expander.sv
// Scoreboard bench for key_expander: AES-128 and AES-256 instances, directed key vectors,
// queued expected read data and done timing checked by a separate monitor.

module tb_key_expander;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b0;
    logic         start_a = 1'b0, busy_a, kv_a, done_a;
    logic [127:0] key_a = '0;
    logic [3:0]   rn_a = '0;
    logic [127:0] rk_a;
    logic         start_b = 1'b0, busy_b, kv_b, done_b;
    logic [255:0] key_b = '0;
    logic [3:0]   rn_b = '0;
    logic [127:0] rk_b;

    key_expander #(.KEY_BITS(128)) u_aes128 (
        .clk(clk), .rst_n(rst_n), .start(start_a), .cipher_key(key_a),
        .busy(busy_a), .keys_valid(kv_a), .done(done_a),
        .round_number(rn_a), .round_key(rk_a)
    );

    key_expander #(.KEY_BITS(256)) u_aes256 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .cipher_key(key_b),
        .busy(busy_b), .keys_valid(kv_b), .done(done_b),
        .round_number(rn_b), .round_key(rk_b)
    );

    localparam logic [127:0] KEY_A    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_A_R1 = 128'hc0393478846c520f0cf5f8b4c028164b;
    localparam logic [127:0] KEY_A_RA = 128'h36d024461d84b8375fc0f9c04cbab6bb;
    localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] KEY_B_RA = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [255:0] KEY_C    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KEY_C_RE = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    int n_cmp = 0;
    int n_bad = 0;
    int gcyc  = 0;
    logic req [2];
    logic ack [2];
    logic [127:0] rd_q [2][$];
    int           rd_tag [2][$];
    int           done_q [2][$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input int act, input int exp);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic monitor();
        logic [127:0] e;
        int           tg;
        int           dc;
        forever begin
            @(posedge clk);
            gcyc++;
            ack[0] = req[0];
            ack[1] = req[1];
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (ack[d]) begin
                    if (rd_q[d].size() == 0) fail($sformatf("dut%0d unexpected read", d), 1, 0);
                    else begin
                        e  = rd_q[d].pop_front();
                        tg = rd_tag[d].pop_front();
                        check($sformatf("dut%0d round_key[%0d]", d, tg), (d == 0) ? rk_a : rk_b, e);
                    end
                end
                if ((d == 0) ? done_a : done_b) begin
                    if (done_q[d].size() == 0) fail($sformatf("dut%0d unexpected done at cycle", d), gcyc, -1);
                    else begin
                        dc = done_q[d].pop_front();
                        if (gcyc != dc) fail($sformatf("dut%0d done cycle", d), gcyc, dc);
                        else n_cmp++;
                    end
                end
            end
        end
    endtask

    task automatic kick(input int d, input logic [255:0] key, input bit expect_done);
        if (expect_done) done_q[d].push_back(gcyc + ((d == 0) ? 41 : 53));
        if (d == 0) begin key_a = key[127:0]; start_a = 1'b1; end
        else        begin key_b = key;        start_b = 1'b1; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_valid(input int d);
        int n = 0;
        while ((((d == 0) ? kv_a : kv_b) !== 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("dut%0d keys_valid within bound", d), {127'b0, (d == 0) ? kv_a : kv_b}, 128'd1);
    endtask

    task automatic rd(input int d, input int n, input logic [127:0] exp);
        if (d == 0) rn_a = 4'(n);
        else        rn_b = 4'(n);
        req[d] = 1'b1;
        rd_q[d].push_back(exp);
        rd_tag[d].push_back(n);
        @(negedge clk);
    endtask

    task automatic rd_end();
        req[0] = 1'b0;
        req[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic stimulus();
        req[0] = 1'b0;
        req[1] = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", {127'b0, busy_a}, 128'd0);
        check("reset keys_valid", {127'b0, kv_a}, 128'd0);
        check("reset done", {127'b0, done_a}, 128'd0);
        check("reset round_key", rk_a, 128'd0);
        check("reset busy 256", {127'b0, busy_b}, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        rd(0, 0, 128'd0);
        rd_end();

        // key A, with a second start at cycle 10 that must be ignored
        kick(0, {128'd0, KEY_A}, 1'b1);
        check("busy after start", {127'b0, busy_a}, 128'd1);
        check("keys_valid after start", {127'b0, kv_a}, 128'd0);
        repeat (9) @(negedge clk);
        kick(0, {128'd0, KEY_B}, 1'b0);
        wait_valid(0);
        rd(0, 0, KEY_A);
        rd(0, 1, KEY_A_R1);
        rd(0, 10, KEY_A_RA);
        for (int n = 11; n < 16; n++) rd(0, n, 128'd0);
        rd_end();

        // back-to-back: start held from the DONE cycle into the next IDLE cycle
        kick(0, {128'd0, KEY_A}, 1'b1);
        wait_valid(0);
        key_a   = KEY_B;
        start_a = 1'b1;
        @(negedge clk);
        check("keys_valid held after start in DONE", {127'b0, kv_a}, 128'd1);
        done_q[0].push_back(gcyc + 41);
        @(negedge clk);
        start_a = 1'b0;
        check("keys_valid drops on restart", {127'b0, kv_a}, 128'd0);
        check("busy on restart", {127'b0, busy_a}, 128'd1);
        wait_valid(0);
        rd(0, 0, KEY_B);
        rd(0, 1, KEY_B_R1);
        rd(0, 10, KEY_B_RA);
        rd_end();

        // reset in the middle of an expansion
        rn_a = 4'd0;
        kick(0, {128'd0, KEY_A}, 1'b0);
        repeat (19) @(negedge clk);
        check("round_key before abort", rk_a, KEY_A);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", {127'b0, busy_a}, 128'd0);
        check("abort keys_valid", {127'b0, kv_a}, 128'd0);
        check("abort round_key", rk_a, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(0, 1, 128'd0);
        rd_end();
        kick(0, {128'd0, KEY_B}, 1'b1);
        wait_valid(0);
        rd(0, 0, KEY_B);
        rd(0, 10, KEY_B_RA);
        rd_end();

        // AES-256
        kick(1, KEY_C, 1'b1);
        check("busy 256", {127'b0, busy_b}, 128'd1);
        wait_valid(1);
        rd(1, 0, KEY_C[255:128]);
        rd(1, 1, KEY_C[127:0]);
        rd(1, 14, KEY_C_RE);
        rd(1, 15, 128'd0);
        rd_end();

        repeat (4) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rd_q[d].size() != 0) fail($sformatf("dut%0d reads left unanswered", d), rd_q[d].size(), 0);
            if (done_q[d].size() != 0) fail($sformatf("dut%0d done pulses missing", d), done_q[d].size(), 0);
        end
    endtask

    initial begin
        fork
            monitor();
            stimulus();
            begin
                #1000000;
                fail("watchdog timeout", 1, 0);
            end
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
